mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the EX stage, beside the integer ALU.
- Executes MULT/MULTU/DIV/DIVU into HI/LO and services MTHI/MTLO writes.
- Exposes HI/LO to the MFHI/MFLO path.
- The pipeline stalls on busy; one operation is in flight at a time.

Parameters:
N, 32, operand width; HI and LO are each N bits.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  launch operation; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
A  in  N  rs operand (multiplicand / dividend)
B  in  N  rt operand (multiplier / divisor)
hi_we  in  1  MTHI write strobe
lo_we  in  1  MTLO write strobe
wdata  in  N  MTHI/MTLO data
busy  out  1  operation in flight
done  out  1  one-cycle pulse; HI/LO just updated by an operation
hi  out  N  HI register
lo  out  N  LO register

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; busy=0, done=0, hi=0, lo=0; all datapath registers cleared.
- Reset mid-operation aborts the operation; HI/LO still go to 0.
- FSM states and transitions:
  - IDLE: start=1 at edge E0 latches op and |A|, |B| (magnitudes for signed ops, raw for unsigned), plus the result signs. Clears the iteration counter. Goes to CALC.
  - CALC: one radix-2 step per cycle for exactly N cycles (edges E1..EN), then SIGN.
    - Multiply: shift-add, 2N-bit product.
    - Divide: restoring; partial remainder N+1 bits.
  - SIGN: at edge EN+1, sign-correct, write hi/lo, go to IDLE. done=1 for the cycle after EN+1.
- Latency: hi/lo valid and done high N+1 cycles after the start edge.
- busy: high from E0 through EN+1 (low in the done cycle); equals state != IDLE.
- Multiply result: {hi,lo} = 2N-bit product.
  - MULT: two's-complement product, negated when sign(A) xor sign(B).
  - MULTU: unsigned product.
- Divide result: lo = quotient, hi = remainder.
  - DIV: quotient negated when signs differ; remainder takes the sign of the dividend (truncating division).
  - DIVU: unsigned.
- Divide by zero (B=0): lo = all ones, hi = A unmodified (both DIV and DIVU); still takes N+1 cycles.
- DIV overflow (A = most-negative, B = -1): lo = most-negative, hi = 0. This falls out of the magnitude datapath; no special case is needed.
- start while busy: ignored.
- hi_we/lo_we:
  - In IDLE: hi/lo <= wdata at the next edge; no done pulse.
  - While busy: ignored.
- start and hi_we/lo_we in the same IDLE cycle: start wins, the write is dropped.
- hi/lo are stable during CALC: old values stay readable until the SIGN edge.
- op, A, B are not required stable after E0; everything is latched.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: at start, if a multiply operand is 0 or the divisor is 0, the FSM goes IDLE->SIGN directly.
  - Result is written at E1; done pulses the cycle after E1 (latency 1).
  - Results are identical to the full path (0 product; divide-by-zero values as above).
- Undefined: latency is always N+1; no zero-detect logic is compiled.

Test Plan:
1. N=32, op=MULT, A=0xFFFFFFFD (-3), B=7 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; done one cycle; busy high exactly 33 cycles.
2. op=MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
3. op=DIV, A=-7 (0xFFFFFFF9), B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. op=DIVU, A=100, B=0 -> lo=0xFFFFFFFF, hi=100. Latency 33 without MDU_EARLY_OUT_EN, 1 with it.
5. Start DIVU 100/7; pulse start (A=1,B=1) and lo_we (wdata=0x55) mid-CALC -> both ignored; final lo=14, hi=2. Then lo_we=1, wdata=0x55 in IDLE -> lo=0x55, no done.
6. Start MULT; drop rst_n at cycle 10 -> immediately busy=0, hi=lo=0; no done; a new start after reset completes normally.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes.
// Optional zero-operand early-out path guarded by MDU_EARLY_OUT_EN.
module mdu_iter #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [N-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN
    } state_e;

    state_e         state_q, state_d;
    logic           is_div_q, is_div_d;
    logic           neg_q, neg_d;
    logic           rneg_q, rneg_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   m_q, m_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic           done_q, done_d;

    logic           op_signed, op_div;
    logic           a_neg, b_neg, b_zero;
    logic [N-1:0]   a_mag, b_mag;
    logic [N:0]     mul_sum;
    logic [N:0]     div_sh;
    logic           div_ge;
    logic [N-1:0]   div_diff;
    logic [2*N-1:0] prod, prod_neg;

    assign op_signed = ~op[0];
    assign op_div    = op[1];
    assign a_neg     = op_signed & A[N-1];
    assign b_neg     = op_signed & B[N-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;
    assign b_zero    = (B == '0);

    // Shift-add: {acc,q} holds the running product, q shifts the multiplier out.
    assign mul_sum  = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);

    // Restoring step; remainder < divisor so the N-bit difference is exact.
    assign div_sh   = {acc_q, q_q[N-1]};
    assign div_ge   = (div_sh >= {1'b0, m_q});
    assign div_diff = div_sh[N-1:0] - m_q;

    assign prod     = {acc_q, q_q};
    assign prod_neg = -prod;

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        acc_d    = acc_q;
        q_d      = q_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CALC;
                    is_div_d = op_div;
                    cnt_d    = '0;
                    acc_d    = '0;
                    if (op_div) begin
                        q_d    = a_mag;
                        m_d    = b_mag;
                        // Divide-by-zero keeps the all-ones quotient unnegated.
                        neg_d  = (a_neg ^ b_neg) & ~b_zero;
                        rneg_d = a_neg;
                    end else begin
                        q_d    = b_mag;
                        m_d    = a_mag;
                        neg_d  = a_neg ^ b_neg;
                        rneg_d = 1'b0;
                    end
`ifdef MDU_EARLY_OUT_EN
                    if (op_div ? b_zero : ((A == '0) || b_zero)) begin
                        state_d = S_SIGN;
                        acc_d   = op_div ? a_mag : '0;
                        q_d     = op_div ? '1 : '0;
                    end
`endif
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    acc_d = div_ge ? div_diff : div_sh[N-1:0];
                    q_d   = {q_q[N-2:0], div_ge};
                end else begin
                    acc_d = mul_sum[N:1];
                    q_d   = {mul_sum[0], q_q[N-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) state_d = S_SIGN;
            end
            S_SIGN: begin
                if (is_div_q) begin
                    lo_d = neg_q ? -q_q : q_q;
                    hi_d = rneg_q ? -acc_q : acc_q;
                end else begin
                    {hi_d, lo_d} = neg_q ? prod_neg : prod;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter; latency expectations follow MDU_EARLY_OUT_EN.
module tb_mdu_iter;

    localparam int FULL_LAT = 33;
`ifdef MDU_EARLY_OUT_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A, B;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int vectors;
    int miscompares;

    mdu_iter #(.N(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launch at the next edge, then count cycles to done; inj injects start/writes mid-flight.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inj, output int lat, output int busyc);
        logic [31:0] hi0, lo0;
        logic        stable;
        hi0    = hi;
        lo0    = lo;
        stable = 1'b1;
        op     = o;
        A      = a;
        B      = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        op    = ~o;
        A     = 32'h1357_9BDF;
        B     = 32'h2468_ACE0;
        lat   = 0;
        busyc = 0;
        for (int k = 1; k <= 100; k++) begin
            if (busy) busyc++;
            if (k == inj) begin
                start = 1'b1;
                A     = 32'd1;
                B     = 32'd1;
                lo_we = 1'b1;
                hi_we = 1'b1;
                wdata = 32'h55;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lo_we = 1'b0;
            hi_we = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            if (hi !== hi0 || lo !== lo0) stable = 1'b0;
        end
        check("busy_in_done", {31'd0, busy}, 32'd0);
        check("hilo_stable", {31'd0, stable}, 32'd1);
        @(posedge clk);
        #1;
        check("done_pulse", {31'd0, done}, 32'd0);
    endtask

    task automatic vec(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input int elat);
        int lat, bc;
        run_op(o, a, b, 0, lat, bc);
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_lo"}, lo, elo);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_busy"}, bc, elat);
    endtask

    initial begin
        int lat, bc;
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        A     = '0;
        B     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        vec("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, FULL_LAT);
        vec("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, FULL_LAT);
        vec("mult_nn", OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_001E, FULL_LAT);
        vec("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, FULL_LAT);
        vec("div_negb", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, FULL_LAT);
        vec("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, FULL_LAT);
        vec("divu_z", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, ZERO_LAT);
        vec("div_z", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, ZERO_LAT);
        vec("mult_z", OP_MULT, 32'd0, 32'hFFFF_FFF0, 32'd0, 32'd0, ZERO_LAT);

        // Start and MT writes during CALC are ignored.
        run_op(OP_DIVU, 32'd100, 32'd7, 5, lat, bc);
        check("inj_lo", lo, 32'd14);
        check("inj_hi", hi, 32'd2);
        check("inj_lat", lat, FULL_LAT);

        // MTLO / MTHI in IDLE.
        lo_we = 1'b1;
        wdata = 32'h55;
        @(posedge clk);
        #1;
        lo_we = 1'b0;
        check("mtlo_lo", lo, 32'h55);
        check("mtlo_hi", hi, 32'd2);
        check("mtlo_done", {31'd0, done}, 32'd0);
        hi_we = 1'b1;
        wdata = 32'hA5;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        check("mthi_hi", hi, 32'hA5);
        check("mthi_lo", lo, 32'h55);
        check("mthi_done", {31'd0, done}, 32'd0);

        // Reset in the middle of an operation.
        op    = OP_MULT;
        A     = 32'd5;
        B     = 32'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("arst_done", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        vec("post_rst", OP_MULT, 32'd5, 32'd6, 32'd0, 32'd30, FULL_LAT);

        // Start wins over a same-cycle MT write.
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hDEAD;
        vec("start_wins", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, FULL_LAT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
